lcd_text_writer: RTL and testbench

Parametrised message writer that streams a character buffer into the LCD interface's display-RAM write port, one character per accepted beat. It maps a linear message onto a multi-line display, wrapping at `LINE_W` and placing each line at a fixed address stride. It optionally clears the whole screen first. It sits between the host, which loads the buffer and pulses `start`, and the LCD interface block, which consumes `wr_en`, `wr_addr`, `wr_data` and applies backpressure through `wr_ready`.

---
 rtl/lcd_pkg.sv | 16 +
 rtl/lcd_msg_buffer.sv | 29 ++
 rtl/lcd_text_writer.sv | 225 ++++++++++++++++++++++
 tb/tb_lcd_text_writer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared state encoding and constants for the LCD text writer and its buffer.
package lcd_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } lcd_state_t;

    localparam logic MODE_MSG   = 1'b0;
    localparam logic MODE_CLEAR = 1'b1;

    localparam logic [7:0] FILL_CHAR_DEFAULT = 8'h20;

endpackage

// File: rtl/lcd_msg_buffer.sv
// Message character store: one synchronous write port and an asynchronous read
// port, so the writer sees a character in the same cycle it asks for it.
module lcd_msg_buffer
    import lcd_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int DATA_W = 8,
    parameter int IDX_W  = 5
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Character storage write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/lcd_text_writer.sv
// Streams a character buffer into the LCD display-RAM write port, optionally
// clearing the screen first and wrapping the message across display lines.
module lcd_text_writer
    import lcd_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int LINE_W      = 16,
    parameter int LINES       = 2,
    parameter int LINE_STRIDE = 16,
    parameter int ADDR_W      = 6,
    parameter logic [DATA_W-1:0] FILL_CHAR = FILL_CHAR_DEFAULT,
    localparam int CAP   = LINES * LINE_W,
    localparam int LEN_W = $clog2(CAP + 1),
    localparam int IDX_W = $clog2(CAP)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              msg_we,
    input  logic [IDX_W-1:0]  msg_addr,
    input  logic [DATA_W-1:0] msg_data,
    input  logic [LEN_W-1:0]  len,
    input  logic              mode,
    input  logic              start,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic              wr_ready,
    output logic              busy,
    output logic              done
);

    localparam int COL_W = (LINE_W > 1) ? $clog2(LINE_W) : 1;
    localparam int LIN_W = (LINES > 1) ? $clog2(LINES) : 1;
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(LINE_W - 1);
    localparam logic [LIN_W-1:0]  LINE_LAST = LIN_W'(LINES - 1);
    localparam logic [ADDR_W-1:0] STRIDE    = ADDR_W'(LINE_STRIDE);
    localparam logic [LEN_W-1:0]  CAP_LEN   = LEN_W'(CAP);

    lcd_state_t        state_r, next_state_s;
    logic [LIN_W-1:0]  line_r, next_line_s;
    logic [COL_W-1:0]  col_r, next_col_s;
    logic [ADDR_W-1:0] base_r, next_base_s;
    logic [IDX_W-1:0]  idx_r, next_idx_s;
    logic [LEN_W-1:0]  eff_len_r, next_eff_len_s;
    logic              wr_en_r, next_wr_en_s;
    logic [ADDR_W-1:0] wr_addr_r, next_wr_addr_s;
    logic [DATA_W-1:0] wr_data_r, next_wr_data_s;
    logic              busy_r, next_busy_s;
    logic              done_r, next_done_s;

    logic              buf_we_s;
    logic [IDX_W-1:0]  rd_idx_s;
    logic [DATA_W-1:0] buf_rdata_s;
    logic [DATA_W-1:0] rd_char_s;
    logic [LEN_W-1:0]  start_len_s;
    logic              beat_s;
    logic              wrap_s;
    logic              last_cell_s;
    logic              last_char_s;
    logic [COL_W-1:0]  adv_col_s;
    logic [LIN_W-1:0]  adv_line_s;
    logic [ADDR_W-1:0] adv_base_s;
    logic [ADDR_W-1:0] adv_addr_s;

    lcd_msg_buffer #(
        .DEPTH  (CAP),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_buf (
        .clk    (clk),
        .we     (buf_we_s),
        .waddr  (msg_addr),
        .wdata  (msg_data),
        .raddr  (rd_idx_s),
        .rdata  (buf_rdata_s)
    );

    // The buffer is frozen during a run; a write coinciding with start is
    // forwarded so the first character already reflects it.
    assign buf_we_s  = msg_we & ~busy_r;
    assign rd_idx_s  = (state_r == S_WRITE) ? idx_r + IDX_W'(1) : {IDX_W{1'b0}};
    assign rd_char_s = (buf_we_s && (msg_addr == rd_idx_s)) ? msg_data : buf_rdata_s;

    assign start_len_s = (len > CAP_LEN) ? CAP_LEN : len;
    assign beat_s      = wr_en_r & wr_ready;
    assign wrap_s      = (col_r == COL_LAST);
    assign last_cell_s = wrap_s && (line_r == LINE_LAST);
    assign last_char_s = ((LEN_W'(idx_r) + LEN_W'(1)) == eff_len_r);

    // Line base advances by the stride on wrap, so no multiply/divide is needed.
    assign adv_col_s  = wrap_s ? {COL_W{1'b0}} : col_r + COL_W'(1);
    assign adv_line_s = wrap_s ? line_r + LIN_W'(1) : line_r;
    assign adv_base_s = wrap_s ? base_r + STRIDE : base_r;
    assign adv_addr_s = adv_base_s + ADDR_W'(adv_col_s);

    // Next-state and next-output decode; outputs are loaded with the beat to
    // present in the following cycle.
    always_comb begin
        next_state_s   = state_r;
        next_line_s    = line_r;
        next_col_s     = col_r;
        next_base_s    = base_r;
        next_idx_s     = idx_r;
        next_eff_len_s = eff_len_r;
        next_wr_en_s   = wr_en_r;
        next_wr_addr_s = wr_addr_r;
        next_wr_data_s = wr_data_r;
        next_busy_s    = busy_r;
        next_done_s    = 1'b0;
        case (state_r)
            S_IDLE, S_DONE: begin
                next_wr_en_s = 1'b0;
                next_busy_s  = 1'b0;
                if (start) begin
                    next_eff_len_s = start_len_s;
                    next_line_s    = {LIN_W{1'b0}};
                    next_col_s     = {COL_W{1'b0}};
                    next_base_s    = {ADDR_W{1'b0}};
                    next_idx_s     = {IDX_W{1'b0}};
                    next_wr_addr_s = {ADDR_W{1'b0}};
                    if (mode == MODE_CLEAR) begin
                        next_state_s   = S_CLEAR;
                        next_wr_en_s   = 1'b1;
                        next_busy_s    = 1'b1;
                        next_wr_data_s = FILL_CHAR;
                    end else if (start_len_s != {LEN_W{1'b0}}) begin
                        next_state_s   = S_WRITE;
                        next_wr_en_s   = 1'b1;
                        next_busy_s    = 1'b1;
                        next_wr_data_s = rd_char_s;
                    end else begin
                        next_state_s = S_DONE;
                        next_done_s  = 1'b1;
                    end
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_CLEAR: begin
                if (beat_s && last_cell_s) begin
                    if (eff_len_r != {LEN_W{1'b0}}) begin
                        next_state_s   = S_WRITE;
                        next_line_s    = {LIN_W{1'b0}};
                        next_col_s     = {COL_W{1'b0}};
                        next_base_s    = {ADDR_W{1'b0}};
                        next_idx_s     = {IDX_W{1'b0}};
                        next_wr_addr_s = {ADDR_W{1'b0}};
                        next_wr_data_s = rd_char_s;
                    end else begin
                        next_state_s = S_DONE;
                        next_wr_en_s = 1'b0;
                        next_busy_s  = 1'b0;
                        next_done_s  = 1'b1;
                    end
                end else if (beat_s) begin
                    next_line_s    = adv_line_s;
                    next_col_s     = adv_col_s;
                    next_base_s    = adv_base_s;
                    next_wr_addr_s = adv_addr_s;
                    next_wr_data_s = FILL_CHAR;
                end else begin
                    next_state_s = S_CLEAR;
                end
            end
            S_WRITE: begin
                if (beat_s && last_char_s) begin
                    next_state_s = S_DONE;
                    next_wr_en_s = 1'b0;
                    next_busy_s  = 1'b0;
                    next_done_s  = 1'b1;
                end else if (beat_s) begin
                    next_line_s    = adv_line_s;
                    next_col_s     = adv_col_s;
                    next_base_s    = adv_base_s;
                    next_idx_s     = idx_r + IDX_W'(1);
                    next_wr_addr_s = adv_addr_s;
                    next_wr_data_s = rd_char_s;
                end else begin
                    next_state_s = S_WRITE;
                end
            end
            default: begin
                next_state_s = S_IDLE;
                next_wr_en_s = 1'b0;
                next_busy_s  = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= S_IDLE;
            line_r    <= {LIN_W{1'b0}};
            col_r     <= {COL_W{1'b0}};
            base_r    <= {ADDR_W{1'b0}};
            idx_r     <= {IDX_W{1'b0}};
            eff_len_r <= {LEN_W{1'b0}};
            wr_en_r   <= 1'b0;
            wr_addr_r <= {ADDR_W{1'b0}};
            wr_data_r <= {DATA_W{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= next_state_s;
            line_r    <= next_line_s;
            col_r     <= next_col_s;
            base_r    <= next_base_s;
            idx_r     <= next_idx_s;
            eff_len_r <= next_eff_len_s;
            wr_en_r   <= next_wr_en_s;
            wr_addr_r <= next_wr_addr_s;
            wr_data_r <= next_wr_data_s;
            busy_r    <= next_busy_s;
            done_r    <= next_done_s;
        end
    end

    assign wr_en   = wr_en_r;
    assign wr_addr = wr_addr_r;
    assign wr_data = wr_data_r;
    assign busy    = busy_r;
    assign done    = done_r;

endmodule

// File: tb/tb_lcd_text_writer.sv
// Scoreboard bench for lcd_text_writer: a reference model queues expected beats,
// a negedge monitor compares every presented beat against the queue head.
module tb_lcd_text_writer;

    localparam int DATA_W      = 8;
    localparam int LINE_W      = 16;
    localparam int LINES       = 2;
    localparam int LINE_STRIDE = 16;
    localparam int ADDR_W      = 6;
    localparam int CAP         = LINES * LINE_W;
    localparam int LEN_W       = 6;
    localparam int IDX_W       = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              msg_we = 1'b0;
    logic [IDX_W-1:0]  msg_addr = '0;
    logic [DATA_W-1:0] msg_data = '0;
    logic [LEN_W-1:0]  len = '0;
    logic              mode = 1'b0;
    logic              start = 1'b0;
    logic              wr_ready = 1'b1;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
    logic              done;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } beat_t;

    beat_t             beat_q[$];
    logic [DATA_W-1:0] buf_m [CAP];

    lcd_text_writer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .msg_we   (msg_we),
        .msg_addr (msg_addr),
        .msg_data (msg_data),
        .len      (len),
        .mode     (mode),
        .start    (start),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every presented beat must equal the queue head; pop on acceptance.
    always @(negedge clk) begin
        if (rst_n && wr_en) begin
            if (beat_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat actual addr=%0h data=%0h required=none", wr_addr, wr_data);
            end else begin
                chk("beat_addr", 32'(wr_addr), 32'(beat_q[0].a));
                chk("beat_data", 32'(wr_data), 32'(beat_q[0].d));
                if (wr_ready) void'(beat_q.pop_front());
            end
        end
    end

    function automatic logic [ADDR_W-1:0] cell_addr(input int i);
        return ADDR_W'((i / LINE_W) * LINE_STRIDE + (i % LINE_W));
    endfunction

    task automatic load(input int a, input logic [DATA_W-1:0] d);
        msg_we   = 1'b1;
        msg_addr = IDX_W'(a);
        msg_data = d;
        @(posedge clk);
        #1;
        msg_we   = 1'b0;
        buf_m[a] = d;
    endtask

    // stall: 0 none, 1 random, 2 three-cycle stall on beat 2.
    task automatic do_run(input int l, input bit m, input int stall, input bit poke, input bit wr0);
        int eff, n, k, cnt;
        bit r [256];
        eff = (l > CAP) ? CAP : l;
        n = (m ? CAP : 0) + eff;
        for (int i = 0; i < 256; i++) begin
            if (stall == 1 && i < 150) r[i] = ($urandom_range(0, 3) != 0);
            else if (stall == 2)       r[i] = !(i >= 3 && i <= 5);
            else                       r[i] = 1'b1;
        end
        k = 0;
        cnt = 0;
        for (int i = 1; i < 256 && cnt < n; i++) begin
            if (r[i]) begin
                cnt++;
                k = i;
            end
        end
        if (wr0) begin
            msg_we   = 1'b1;
            msg_addr = '0;
            msg_data = DATA_W'($urandom);
            buf_m[0] = msg_data;
        end
        if (m) begin
            for (int i = 0; i < CAP; i++) beat_q.push_back('{cell_addr(i), 8'h20});
        end
        for (int i = 0; i < eff; i++) beat_q.push_back('{cell_addr(i), buf_m[i]});
        len   = LEN_W'(l);
        mode  = m;
        start = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        msg_we = 1'b0;
        for (int j = 0; j <= k; j++) begin
            chk("busy", 32'(busy), 32'(j < k));
            chk("done", 32'(done), 32'(j == k));
            if (j == k) break;
            wr_ready = r[j + 1];
            if (poke && j == 3) begin
                start    = 1'b1;
                msg_we   = 1'b1;
                msg_addr = IDX_W'($urandom);
                msg_data = DATA_W'($urandom);
            end
            @(posedge clk);
            #1;
            start  = 1'b0;
            msg_we = 1'b0;
        end
        wr_ready = 1'b1;
        chk("wr_en_at_done", 32'(wr_en), 32'(0));
        chk("beats_left", 32'(beat_q.size()), 32'(0));
        beat_q.delete();
    endtask

    initial begin
        string s;
        s = "LINI MESTAR";
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wr_en", 32'(wr_en), 32'(0));
        chk("rst_wr_addr", 32'(wr_addr), 32'(0));
        chk("rst_wr_data", 32'(wr_data), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < CAP; i++) load(i, (i < 11) ? s[i] : DATA_W'($urandom));

        do_run(11, 1'b0, 0, 1'b0, 1'b0);
        do_run(18, 1'b0, 0, 1'b0, 1'b0);
        do_run(40, 1'b0, 0, 1'b0, 1'b0);
        do_run(11, 1'b0, 2, 1'b0, 1'b0);
        do_run(2,  1'b1, 0, 1'b0, 1'b0);
        do_run(0,  1'b1, 0, 1'b0, 1'b0);
        do_run(0,  1'b0, 0, 1'b0, 1'b0);
        do_run(20, 1'b0, 1, 1'b1, 1'b0);
        do_run(32, 1'b0, 0, 1'b0, 1'b0);
        do_run(5,  1'b0, 0, 1'b0, 1'b1);
        repeat (12) begin
            if ($urandom_range(0, 1) == 1) load($urandom_range(0, CAP - 1), DATA_W'($urandom));
            do_run($urandom_range(0, 40), 1'($urandom_range(0, 1)), $urandom_range(0, 1),
                   1'b0, 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a run, while beat 5 is presented.
        for (int i = 0; i < 18; i++) beat_q.push_back('{cell_addr(i), buf_m[i]});
        len   = LEN_W'(18);
        mode  = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_wr_en", 32'(wr_en), 32'(0));
        chk("midrst_busy", 32'(busy), 32'(0));
        chk("midrst_done", 32'(done), 32'(0));
        chk("midrst_wr_addr", 32'(wr_addr), 32'(0));
        beat_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < CAP; i++) load(i, DATA_W'($urandom));
        do_run(11, 1'b0, 0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
